vram_writer: RTL and testbench
==============================

VRAM_WRITER -- requirements
Module: vram_writer

Interface
- REQ-001 SHALL have parameter DEPTH, default 4: write-buffer entries; power of 2, range 2..16.
- REQ-002 SHALL have port clk_sys, input, 1: master clock, the only clock.
- REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset.
- REQ-004 SHALL have port ce_6mn, input, 1: one-clk_sys strobe per 6 MHz pixel period.
- REQ-005 SHALL have port cpu_slot, input, 1: high while the current pixel period is a CPU-owned VRAM slot; sampled only with ce_6mn.
- REQ-006 SHALL have ports wr_req (input, 1), wr_addr (input, 19) and wr_data (input, 8): CPU byte write request.
- REQ-007 SHALL have port wr_ready, output, 1: high when the buffer can accept a write.
- REQ-008 SHALL have ports rd_req (input, 1) and rd_addr (input, 19): CPU byte read request.
- REQ-009 SHALL have ports rd_busy (output, 1), rd_valid (output, 1) and rd_data (output, 8): read status and result.
- REQ-010 SHALL have ports mem_addr (output, 19), mem_din (output, 8), mem_we (output, 1), mem_rd (output, 1) and mem_dout (input, 8): VRAM byte port.

Function
- REQ-011 SHALL accept a write on a clk_sys edge with wr_req and wr_ready both high, pushing {wr_addr, wr_data} into a FIFO of DEPTH entries.
- REQ-012 SHALL drive wr_ready as (count < DEPTH) from the registered count; a push in the same cycle as a pop SHALL be accepted only when not full, leaving count unchanged.
- REQ-013 SHALL ignore wr_req while full, with no state change and no error flag.
- REQ-014 SHALL issue at most one memory operation per slot, only on a clk_sys edge where ce_6mn and cpu_slot are both high.
- REQ-015 SHALL assert mem_we for exactly one clk_sys cycle coinciding with that ce_6mn edge, with mem_addr and mem_din holding the FIFO head, and SHALL pop the head on the same edge.
- REQ-016 SHALL wrap FIFO read and write pointers modulo DEPTH.
- REQ-017 SHALL run a state machine with states IDLE, RD_WAIT, RD_DATA and RD_FWD.
- REQ-018 SHALL accept rd_req only in IDLE, holding rd_busy high from the accept edge until the rd_valid edge inclusive.
- REQ-019 SHALL latch rd_addr on accept and move IDLE->RD_WAIT, or IDLE->RD_FWD on a forwarding hit.
- REQ-020 SHALL, in RD_WAIT, issue the read once its issue condition holds: assert mem_rd for one cycle on the slot edge with mem_addr = latched address, then move to RD_DATA.
- REQ-021 SHALL, in RD_DATA, capture mem_dout on the next ce_6mn edge, pulse rd_valid for one cycle with rd_data, and return to IDLE.
- REQ-022 SHALL, in RD_FWD, pulse rd_valid one clk_sys cycle after accept with the newest matching buffered data, then return to IDLE.
- REQ-023 SHALL, in RD_WAIT, give a pending read priority over buffer drain when its issue condition holds.
- REQ-024 SHALL keep rd_data stable between rd_valid pulses.
- REQ-025 SHALL drive mem_addr and mem_din to zero whenever neither mem_we nor mem_rd is asserted.

Reset
- REQ-026 SHALL, while reset is low, empty the FIFO and force the state to IDLE, aborting any read with no rd_valid.
- REQ-027 SHALL hold mem_we, mem_rd, rd_valid, rd_busy, rd_data, mem_addr and mem_din at 0 and wr_ready at 1 on the first cycle after reset.

Configuration
- REQ-028 SHALL, with VRAM_WBUF_FWD_EN defined, compare a read address against all valid entries on accept; a hit goes to RD_FWD, a miss issues at the next slot even if writes are pending.
- REQ-029 SHALL, without VRAM_WBUF_FWD_EN, omit the comparators and RD_FWD, and hold a read in RD_WAIT until the FIFO is empty, giving strict write-before-read ordering.

Structure
- REQ-030 SHALL take VRAM_AW = 19, typedef vram_addr_t, the write-entry struct typedef and the state enum from shared package vram_pkg.
- REQ-031 SHALL implement the buffer as sub-module vram_wbuf, exposing push, pop, head, count and (when VRAM_WBUF_FWD_EN is defined) a match port.

Verification
- REQ-032 SHALL cover: write 0x12345<-0xA5 with cpu_slot high every 8th period -> exactly one mem_we at the next slot edge, addr 0x12345, din 0xA5.
- REQ-033 SHALL cover: 5 writes back-to-back, DEPTH=4, no slots -> wr_ready low after the 4th; the 5th is not accepted until after one slot drains.
- REQ-034 SHALL cover, with forwarding: write 0x00100<-0x3C, then writes 0x00100<-0x5A and 0x00200<-0x11 (no slots), read 0x00100 -> rd_valid one cycle after accept, rd_data 0x5A, no mem_rd.
- REQ-035 SHALL cover, without forwarding: two writes pending, then read 0x00200 -> mem_rd only after the 2nd mem_we; rd_data equals mem_dout at the following ce_6mn.
- REQ-036 SHALL cover: reset low during RD_DATA with 3 entries buffered -> no rd_valid, no further mem_we, wr_ready=1, rd_busy=0.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: shared address type, write-buffer entry and read-FSM state for the VRAM writer.
package vram_pkg;
    localparam int VRAM_AW = 19;
    typedef logic [VRAM_AW-1:0] vram_addr_t;
    typedef struct packed {
        vram_addr_t addr;
        logic [7:0] data;
    } wentry_t;
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, RD_FWD} state_t;
endpackage

// File: rtl/vram_wbuf.sv
// vram_wbuf: DEPTH-entry write FIFO; with VRAM_WBUF_FWD_EN it also reports the
// newest buffered entry matching match_addr.
module vram_wbuf
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     push,
    input  wentry_t                  din,
    input  logic                     pop,
    output wentry_t                  head,
    output logic [$clog2(DEPTH):0]   count
`ifdef VRAM_WBUF_FWD_EN
    ,
    input  vram_addr_t               match_addr,
    output logic                     match,
    output logic [7:0]               match_data
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    wentry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign do_push = push && count < FULL;
    assign do_pop  = pop && count != '0;
    assign head    = mem[rd_ptr];
    // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end
`ifdef VRAM_WBUF_FWD_EN
    // Scan oldest to newest so the last hit is the newest write.
    always_comb begin
        match      = 1'b0;
        match_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PW+1)'(k) < count && mem[rd_ptr + PW'(k)].addr == match_addr) begin
                match      = 1'b1;
                match_data = mem[rd_ptr + PW'(k)].data;
            end
        end
    end
`endif
endmodule

// File: rtl/vram_writer.sv
// vram_writer: buffers CPU VRAM writes and drains/reads them in CPU slots.
// Define VRAM_WBUF_FWD_EN to forward reads from the write buffer.
module vram_writer
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ce_6mn,
    input  logic               cpu_slot,
    input  logic               wr_req,
    input  logic [VRAM_AW-1:0] wr_addr,
    input  logic [7:0]         wr_data,
    output logic               wr_ready,
    input  logic               rd_req,
    input  logic [VRAM_AW-1:0] rd_addr,
    output logic               rd_busy,
    output logic               rd_valid,
    output logic [7:0]         rd_data,
    output logic [VRAM_AW-1:0] mem_addr,
    output logic [7:0]         mem_din,
    output logic               mem_we,
    output logic               mem_rd,
    input  logic [7:0]         mem_dout
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    state_t state;
    vram_addr_t raddr;
    wentry_t head;
    logic [PW:0] count;
    logic slot, rd_issue, drain, accept;
`ifdef VRAM_WBUF_FWD_EN
    logic hit;
    logic [7:0] match_data, fwd_data;
`endif
    vram_wbuf #(.DEPTH(DEPTH)) u_wbuf (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .push       (wr_req && wr_ready),
        .din        ('{addr: wr_addr, data: wr_data}),
        .pop        (drain),
        .head       (head),
        .count      (count)
`ifdef VRAM_WBUF_FWD_EN
        ,
        .match_addr (rd_addr),
        .match      (hit),
        .match_data (match_data)
`endif
    );
    assign slot = reset && ce_6mn && cpu_slot;
`ifdef VRAM_WBUF_FWD_EN
    assign rd_issue = slot && state == RD_WAIT;
`else
    assign rd_issue = slot && state == RD_WAIT && count == '0;
`endif
    assign drain    = slot && count != '0 && !rd_issue;
    assign accept   = rd_req && state == IDLE && !rd_busy;
    assign wr_ready = count < FULL;
    assign mem_we   = drain;
    assign mem_rd   = rd_issue;
    assign mem_addr = rd_issue ? raddr : drain ? head.addr : '0;
    assign mem_din  = drain ? head.data : '0;
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state    <= IDLE;
            raddr    <= '0;
            rd_valid <= 1'b0;
            rd_busy  <= 1'b0;
            rd_data  <= '0;
`ifdef VRAM_WBUF_FWD_EN
            fwd_data <= '0;
`endif
        end else begin
            rd_valid <= 1'b0;
            rd_busy  <= accept || state != IDLE;
            case (state)
                IDLE: if (accept) begin
                    raddr <= rd_addr;
`ifdef VRAM_WBUF_FWD_EN
                    fwd_data <= match_data;
                    state    <= hit ? RD_FWD : RD_WAIT;
`else
                    state <= RD_WAIT;
`endif
                end
                RD_WAIT: if (rd_issue) state <= RD_DATA;
                RD_DATA: if (ce_6mn) begin
                    rd_data  <= mem_dout;
                    rd_valid <= 1'b1;
                    state    <= IDLE;
                end
`ifdef VRAM_WBUF_FWD_EN
                RD_FWD: begin
                    rd_data  <= fwd_data;
                    rd_valid <= 1'b1;
                    state    <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer: directed self-checking bench for vram_writer (DEPTH=4),
// covering both VRAM_WBUF_FWD_EN builds.
module tb_vram_writer;
    logic        clk_sys = 0;
    logic        reset = 0;
    logic        ce_6mn = 0, cpu_slot = 0;
    logic        wr_req = 0;
    logic [18:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready;
    logic        rd_req = 0;
    logic [18:0] rd_addr = '0;
    logic        rd_busy, rd_valid;
    logic [7:0]  rd_data;
    logic [18:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we, mem_rd;
    logic [7:0]  mem_dout = '0;

    int checks = 0, errors = 0;
    int we_cnt = 0, rd_cnt = 0, vld_cnt = 0;
    logic [18:0] we_addr = '0, rd_seen = '0;
    logic [7:0]  we_din = '0;
    int wb, rb, vb;

    vram_writer #(.DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_6mn(ce_6mn), .cpu_slot(cpu_slot),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_valid(rd_valid),
        .rd_data(rd_data), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_rd(mem_rd), .mem_dout(mem_dout)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (mem_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= mem_addr;
            we_din  <= mem_din;
        end
        if (mem_rd) begin
            rd_cnt  <= rd_cnt + 1;
            rd_seen <= mem_addr;
        end
        if (rd_valid) vld_cnt <= vld_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ce_edge(input logic s);
        ce_6mn = 1; cpu_slot = s;
        cyc();
        ce_6mn = 0; cpu_slot = 0;
    endtask

    task automatic write(input logic [18:0] a, input logic [7:0] d);
        wr_req = 1; wr_addr = a; wr_data = d;
        cyc();
        wr_req = 0;
    endtask

    task automatic read(input logic [18:0] a);
        rd_req = 1; rd_addr = a;
        cyc();
        rd_req = 0;
    endtask

    initial begin
        // reset state
        cyc(); cyc();
        check("rst_wr_ready", wr_ready, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_rd_busy", rd_busy, 0);
        reset = 1;
        cyc();
        check("post_rst_rd_valid", rd_valid, 0);
        check("post_rst_rd_data", rd_data, 0);
        check("post_rst_mem_addr", mem_addr, 0);
        check("post_rst_mem_din", mem_din, 0);
        check("post_rst_wr_ready", wr_ready, 1);

        // single write drains at the next slot edge only
        wb = we_cnt;
        write(19'h12345, 8'hA5);
        repeat (3) begin cyc(); ce_edge(0); end
        check("w1_no_slot", we_cnt - wb, 0);
        ce_6mn = 1; cpu_slot = 1; #1;
        check("w1_we_comb", mem_we, 1);
        check("w1_addr_comb", mem_addr, 19'h12345);
        check("w1_din_comb", mem_din, 8'hA5);
        cyc(); ce_6mn = 0; cpu_slot = 0;
        check("w1_we_cnt", we_cnt - wb, 1);
        check("w1_we_addr", we_addr, 19'h12345);
        check("w1_we_din", we_din, 8'hA5);
        check("w1_idle_addr", mem_addr, 0);
        ce_edge(1);
        check("w1_once", we_cnt - wb, 1);

        // fill to DEPTH, fifth write waits for a drain
        wb = we_cnt;
        wr_req = 1;
        for (int i = 0; i < 4; i++) begin
            wr_addr = 19'h100 + 19'(i); wr_data = 8'h10 + 8'(i);
            cyc();
        end
        check("full_ready", wr_ready, 0);
        wr_addr = 19'h104; wr_data = 8'h14;
        cyc();
        check("full_reject_ready", wr_ready, 0);
        ce_edge(1);
        check("full_pop_addr", we_addr, 19'h100);
        check("full_ready_after_pop", wr_ready, 1);
        cyc();
        wr_req = 0;
        check("full_fifth_accepted", wr_ready, 0);
        for (int i = 1; i < 5; i++) begin
            ce_edge(1);
            check("full_drain_addr", we_addr, 19'h100 + 19'(i));
            check("full_drain_din", we_din, 8'h10 + 8'(i));
        end
        check("full_drain_cnt", we_cnt - wb, 5);
        check("full_empty_ready", wr_ready, 1);

`ifdef VRAM_WBUF_FWD_EN
        // forwarding hit returns newest data, no memory read
        rb = rd_cnt; wb = we_cnt;
        write(19'h00100, 8'h3C);
        write(19'h00100, 8'h5A);
        write(19'h00200, 8'h11);
        read(19'h00100);
        check("fwd_busy", rd_busy, 1);
        check("fwd_not_yet", rd_valid, 0);
        cyc();
        check("fwd_valid", rd_valid, 1);
        check("fwd_data", rd_data, 8'h5A);
        cyc();
        check("fwd_valid_pulse", rd_valid, 0);
        check("fwd_no_mem_rd", rd_cnt - rb, 0);
        // a miss goes ahead of pending writes
        read(19'h00500);
        ce_6mn = 1; cpu_slot = 1; #1;
        check("fwd_miss_rd", mem_rd, 1);
        check("fwd_miss_no_we", mem_we, 0);
        check("fwd_miss_addr", mem_addr, 19'h00500);
        cyc(); ce_6mn = 0; cpu_slot = 0;
        mem_dout = 8'h6E;
        ce_edge(0);
        check("fwd_miss_valid", rd_valid, 1);
        check("fwd_miss_data", rd_data, 8'h6E);
        repeat (3) ce_edge(1);
        check("fwd_drain_cnt", we_cnt - wb, 3);
        check("fwd_drain_last", we_addr, 19'h00200);
`else
        // read waits for buffered writes to drain first
        rb = rd_cnt; wb = we_cnt;
        write(19'h00300, 8'h21);
        write(19'h00400, 8'h22);
        read(19'h00200);
        check("ord_busy", rd_busy, 1);
        ce_edge(1);
        check("ord_we1_addr", we_addr, 19'h00300);
        check("ord_no_rd1", rd_cnt - rb, 0);
        ce_edge(1);
        check("ord_we2_addr", we_addr, 19'h00400);
        check("ord_no_rd2", rd_cnt - rb, 0);
        ce_6mn = 1; cpu_slot = 1; #1;
        check("ord_rd_comb", mem_rd, 1);
        check("ord_rd_addr_comb", mem_addr, 19'h00200);
        cyc(); ce_6mn = 0; cpu_slot = 0;
        check("ord_rd_cnt", rd_cnt - rb, 1);
        check("ord_rd_seen", rd_seen, 19'h00200);
        check("ord_we_total", we_cnt - wb, 2);
        mem_dout = 8'hC3;
        cyc();
        check("ord_wait_ce", rd_valid, 0);
        ce_edge(0);
        check("ord_valid", rd_valid, 1);
        check("ord_data", rd_data, 8'hC3);
        check("ord_busy_incl", rd_busy, 1);
        mem_dout = 8'h00;
        cyc();
        check("ord_valid_pulse", rd_valid, 0);
        check("ord_busy_clear", rd_busy, 0);
        cyc();
        check("ord_data_stable", rd_data, 8'hC3);
`endif

        // reset while in RD_DATA with three writes buffered
        mem_dout = 8'h77;
        read(19'h00050);
        ce_edge(1);
        check("rst_rd_issued_busy", rd_busy, 1);
        write(19'h00600, 8'h01);
        write(19'h00601, 8'h02);
        write(19'h00602, 8'h03);
        check("rst_three_ready", wr_ready, 1);
        wb = we_cnt; vb = vld_cnt;
        reset = 0; ce_6mn = 1; cpu_slot = 1; #1;
        check("rst_we_gated", mem_we, 0);
        cyc();
        check("rst_no_valid", rd_valid, 0);
        check("rst_busy", rd_busy, 0);
        check("rst_ready", wr_ready, 1);
        ce_6mn = 0; cpu_slot = 0; reset = 1;
        cyc();
        ce_edge(1);
        ce_edge(1);
        check("rst_no_more_we", we_cnt - wb, 0);
        check("rst_no_valid_cnt", vld_cnt - vb, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
